ofmap_drain_ctrl: RTL and testbench
===================================

Name: ofmap_drain_ctrl

Overview:
- Sequences the read side of the 512-bit output feature-map memory (4 banks x 128 bits, 1024 rows).
- On a start command it reads a contiguous block of rows starting at a base address.
- It absorbs the memory's fixed read latency and streams the rows out over a valid/ready interface with full-throughput backpressure handling.
- It sits between the ofmap memory read port and the host/DMA writeback path.

Parameters:
- ADDR_BITS, 10, row address width of the output memory.
- DATA_WIDTH, 512, row width in bits.
- RD_LATENCY, 1, cycles from mem_rdaddress to valid mem_rdata. Legal range is 1..3.
- FIFO_DEPTH, 4, output buffer entries. Must be >= RD_LATENCY+1; elaboration error otherwise.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle command pulse; sampled only in IDLE.
- base_addr  input  ADDR_BITS  first row to read; sampled with start.
- num_rows  input  ADDR_BITS+1  row count, 1..1024; sampled with start.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse after the last row is accepted downstream.
- cmd_err  output  1  one-cycle pulse when start is seen while busy, or with num_rows==0 or >1024.
- mem_rdaddress  output  ADDR_BITS  to memory rdaddress.
- mem_rd_issue  output  1  high when mem_rdaddress carries a real read (debug/power).
- mem_rdata  input  DATA_WIDTH  from memory rdata_out.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_data  output  DATA_WIDTH  row data.
- out_last  output  1  high with the final row of the command.

Behaviour:
- Reset values: busy=0, done=0, cmd_err=0, out_valid=0, out_last=0, mem_rd_issue=0, mem_rdaddress=0, out_data=0. FIFO is emptied, in-flight counter=0, state=IDLE.
- Reset mid-command aborts the command immediately. No done pulse is produced, and read data returning after reset is discarded.
- FSM states:
  - IDLE: start with a legal num_rows latches base/count and goes to RUN. start with an illegal count pulses cmd_err and stays in IDLE.
  - RUN: issues reads; moves to DRAIN in the cycle the last read is issued.
  - DRAIN: waits for in-flight==0 and the FIFO to be empty; then goes to DONE.
  - DONE: done=1 for one cycle, busy=0, then back to IDLE.
- start in RUN, DRAIN or DONE is ignored and pulses cmd_err. The active command is unaffected.
- Read issue rule: in RUN, issue one read per cycle while fifo_count + inflight_count < FIFO_DEPTH, counting this cycle's pop. This credit scheme guarantees no returned data is ever dropped.
- Read address sequencing:
  - The first read goes to base_addr; each subsequent read increments the address.
  - The address wraps modulo 2^ADDR_BITS (row 1023 is followed by row 0).
- Read return path:
  - Return data is tracked by a RD_LATENCY-deep valid shift register.
  - Returned mem_rdata is pushed into the FIFO in the cycle it becomes valid.
- Output stream rules:
  - out_valid = FIFO not empty; out_data/out_last come from the FIFO head.
  - A transfer happens when out_valid && out_ready. Once asserted, out_valid and out_data stay stable until the transfer.
  - out_last is tagged on the entry of read index num_rows-1.
- Throughput: with out_ready held at 1, one row per cycle.
  - First out_valid appears RD_LATENCY+1 cycles after the start cycle (one cycle to latch the command, then RD_LATENCY).
  - done asserts the cycle after the out_last transfer.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- num_rows=1024: every row is read exactly once, the address wraps back to base, and there is no duplicate read.
- Counters are ADDR_BITS+1 wide; no overflow is possible.

Decomposition:
- Package ofmap_pkg:
  - typedef drain_state_t {IDLE, RUN, DRAIN, DONE}.
  - Constants OFMAP_ADDR_BITS=10, OFMAP_ROW_WIDTH=512, OFMAP_ROWS=1024.
  - typedef ofmap_row_t as logic [3:0][127:0].
- One sub-module, ofmap_stream_fifo: synchronous FIFO, DATA_WIDTH+1 wide (data + last), parameterised depth.
  - Ports: push, pop, full, empty, count.
  - Synchronous active-high reset; show-ahead head output.

Test Plan:
- Basic: start with base=5, num_rows=4, out_ready=1 → reads 5,6,7,8. out_valid on cycles start+2..start+5 (RD_LATENCY=1) with the row data of 5..8, out_last on row 8, done at start+6.
- Wrap: base=1022, num_rows=4 → addresses 1022,1023,0,1 in order, data matches, out_last on row 1.
- Backpressure: base=0, num_rows=16, out_ready toggling 1,0,0,1 pattern → all 16 rows delivered in order, none duplicated or lost, out_data stable while stalled. In-flight + FIFO never exceeds 4.
- Full range: num_rows=1024, base=512, out_ready=1 → 1024 transfers in 1024 consecutive cycles, done after the last one.
- Command errors: start with num_rows=0 → cmd_err pulse, busy stays 0. start during RUN → cmd_err pulse, the original command completes normally.
- Reset mid-command: assert reset for 1 cycle after 3 of 10 rows are transferred → next cycle all outputs are 0, no done pulse. A new start (base=100, num_rows=2) then delivers exactly rows 100,101.

Source files
------------

// File: rtl/ofmap_drain_ctrl_pkg.sv
// Shared types and geometry for the output feature-map memory and its drain path.
// The ofmap memory is 1024 rows of four 128-bit banks.
package ofmap_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} drain_state_t;

  localparam int OFMAP_ADDR_BITS = 10;
  localparam int OFMAP_ROW_WIDTH = 512;
  localparam int OFMAP_ROWS      = 1024;

  typedef logic [3:0][127:0] ofmap_row_t;

endpackage

// File: rtl/ofmap_drain_ctrl_fifo.sv
// Show-ahead synchronous FIFO holding returned rows plus their last flag.
// The head entry is presented combinationally and reads as zero while empty.
module ofmap_stream_fifo
  import ofmap_pkg::*;
#(
  parameter int WIDTH = OFMAP_ROW_WIDTH + 1,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_pushData,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [WIDTH-1:0]           o_headData
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_count    = r_count;
  assign o_headData = o_empty ? '0 : r_mem[r_rdPtr];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  always_ff @(posedge clock) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ofmap_drain_ctrl.sv
// Reads a contiguous block of ofmap rows and streams them out over valid/ready.
// Reads are credit-limited so the output FIFO can always absorb every return.
module ofmap_drain_ctrl
  import ofmap_pkg::*;
#(
  parameter int ADDR_BITS  = OFMAP_ADDR_BITS,
  parameter int DATA_WIDTH = OFMAP_ROW_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  base_addr,
  input  logic [ADDR_BITS:0]    num_rows,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err,
  output logic [ADDR_BITS-1:0]  mem_rdaddress,
  output logic                  mem_rd_issue,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2);
  localparam int INF_W = $clog2(RD_LATENCY + 1);

  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_latencyCheck
    $error("RD_LATENCY must be in 1..3");
  end
  if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_depthCheck
    $error("FIFO_DEPTH must be at least RD_LATENCY+1");
  end

  drain_state_t          r_state;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [ADDR_BITS:0]    r_numRows;
  logic [ADDR_BITS:0]    r_issued;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cmdErr;
  logic [RD_LATENCY-1:0] r_vld;
  logic [RD_LATENCY-1:0] r_vldLast;
  logic [INF_W-1:0]      r_inflight;

  logic                  w_legal;
  logic                  w_issue;
  logic                  w_issueLast;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_headLast;
  logic [CNT_W-1:0]      w_fifoCount;
  logic [DATA_WIDTH:0]   w_head;
  logic [SUM_W-1:0]      w_outstanding;
  logic [SUM_W-1:0]      w_limit;

  assign w_legal = (num_rows != '0) && (num_rows <= {1'b1, {ADDR_BITS{1'b0}}});

  // Rows already buffered or in flight must stay within FIFO_DEPTH after this cycle's pop.
  assign w_pop         = !w_empty && out_ready;
  assign w_outstanding = SUM_W'(w_fifoCount) + SUM_W'(r_inflight);
  assign w_limit       = SUM_W'(FIFO_DEPTH) + SUM_W'(w_pop);
  assign w_issue       = (r_state == RUN) && (w_outstanding < w_limit) && !(w_full && !w_pop);
  assign w_issueLast   = (r_issued == r_numRows - (ADDR_BITS + 1)'(1));
  assign w_push        = r_vld[RD_LATENCY-1];
  assign w_headLast    = w_head[DATA_WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_numRows <= '0;
      r_issued  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cmdErr  <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_cmdErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_legal) begin
              r_addr    <= base_addr;
              r_numRows <= num_rows;
              r_issued  <= '0;
              r_busy    <= 1'b1;
              r_state   <= RUN;
            end else begin
              r_cmdErr <= 1'b1;
            end
          end
        end
        RUN: begin
          if (start) r_cmdErr <= 1'b1;
          if (w_issue) begin
            r_addr   <= r_addr + ADDR_BITS'(1);
            r_issued <= r_issued + (ADDR_BITS + 1)'(1);
            if (w_issueLast) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (start) r_cmdErr <= 1'b1;
          // The tagged row leaving the FIFO means nothing is buffered or in flight.
          if (w_pop && w_headLast) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (start) r_cmdErr <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld      <= '0;
      r_vldLast  <= '0;
      r_inflight <= '0;
    end else begin
      r_vld[0]     <= w_issue;
      r_vldLast[0] <= w_issue && w_issueLast;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i]     <= r_vld[i-1];
        r_vldLast[i] <= r_vldLast[i-1];
      end
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + INF_W'(1);
        2'b01:   r_inflight <= r_inflight - INF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  ofmap_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_push),
    .i_pushData ({r_vldLast[RD_LATENCY-1], mem_rdata}),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_fifoCount),
    .o_headData (w_head)
  );

  assign busy          = r_busy;
  assign done          = r_done;
  assign cmd_err       = r_cmdErr;
  assign mem_rdaddress = r_addr;
  assign mem_rd_issue  = w_issue;
  assign out_valid     = !w_empty;
  assign out_data      = w_head[DATA_WIDTH-1:0];
  assign out_last      = w_headLast;

endmodule

// File: tb/tb_ofmap_drain_ctrl.sv
// Directed bench for ofmap_drain_ctrl with a latency-1 memory model.
// Each scenario task drives one command and compares against hand-derived expectations.
module tb_ofmap_drain_ctrl;
  import ofmap_pkg::*;

  localparam int AW = OFMAP_ADDR_BITS;
  localparam int DW = OFMAP_ROW_WIDTH;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] baseAddr;
  logic [AW:0]   numRows;
  logic          busy, done, cmdErr;
  logic [AW-1:0] memRdaddress;
  logic          memRdIssue;
  logic [DW-1:0] memRdata;
  logic          outValid, outReady, outLast;
  logic [DW-1:0] outData;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] issAddr[$];
  logic [DW-1:0] xData[$];
  logic          xLast[$];
  int            xCyc[$];
  int            doneCyc, errPulses, maxOut, stallViol;
  logic          busyAt0, busyAtDone;

  ofmap_drain_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .base_addr     (baseAddr),
    .num_rows      (numRows),
    .busy          (busy),
    .done          (done),
    .cmd_err       (cmdErr),
    .mem_rdaddress (memRdaddress),
    .mem_rd_issue  (memRdIssue),
    .mem_rdata     (memRdata),
    .out_valid     (outValid),
    .out_ready     (outReady),
    .out_data      (outData),
    .out_last      (outLast)
  );

  always #5 clock = ~clock;

  function automatic ofmap_row_t rowOf(input logic [AW-1:0] a);
    ofmap_row_t r;
    for (int l = 0; l < 4; l++) r[l] = {22'h2A5A5, a, 32'(l), 32'(~a), 32'(a) + 32'h1000_0000};
    return r;
  endfunction

  // Memory returns the addressed row one cycle after the address is presented.
  always @(posedge clock) memRdata <= rowOf(memRdaddress);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one command and records issues, transfers and status into the scoreboard queues.
  task automatic runStream(input logic [AW-1:0] b, input logic [AW:0] n, input int readyMode,
                           input int budget, input int injectAt, input int stopAfter);
    logic          prevValid, prevReady;
    logic [DW-1:0] prevData;
    int            issued, xfers;
    issAddr.delete(); xData.delete(); xLast.delete(); xCyc.delete();
    doneCyc = -1; errPulses = 0; maxOut = 0; stallViol = 0;
    busyAt0 = 1'b0; busyAtDone = 1'b1;
    issued = 0; xfers = 0; prevValid = 1'b0; prevReady = 1'b0; prevData = '0;
    baseAddr = b; numRows = n; start = 1'b1; outReady = 1'b1;
    tick();
    for (int k = 0; k < budget; k++) begin
      start    = (k == injectAt);
      outReady = (readyMode == 0) || (k % 4 == 0) || (k % 4 == 3);
      #1;
      if (k == 0) busyAt0 = busy;
      if (cmdErr) errPulses++;
      if (prevValid && !prevReady && (!outValid || outData !== prevData)) stallViol++;
      if (memRdIssue) begin
        issAddr.push_back(memRdaddress);
        issued++;
      end
      if (outValid && outReady) begin
        xData.push_back(outData);
        xLast.push_back(outLast);
        xCyc.push_back(k);
        xfers++;
      end
      if (issued - xfers > maxOut) maxOut = issued - xfers;
      prevValid = outValid; prevReady = outReady; prevData = outData;
      if (done && doneCyc < 0) begin
        doneCyc    = k;
        busyAtDone = busy;
      end
      if (doneCyc >= 0 || (stopAfter >= 0 && xfers >= stopAfter)) break;
      tick();
    end
    start = 1'b0;
    if (doneCyc >= 0) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; outReady = 1'b0; baseAddr = '0; numRows = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (cmdErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_err: got %b expected 0", cmdErr); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid); end
    checks++; if (outLast !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last: got %b expected 0", outLast); end
    checks++; if (memRdIssue !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_issue: got %b expected 0", memRdIssue); end
    checks++; if (memRdaddress !== '0) begin errors++; $display("[TB] FAIL reset_rdaddress: got %0d expected 0", memRdaddress); end
    checks++; if (outData !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", outData); end
  endtask

  task automatic test_basic();
    runStream(AW'(5), (AW+1)'(4), 0, 20, -1, -1);
    checks++; if (busyAt0 !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 1", busyAt0); end
    checks++; if (issAddr.size() != 4) begin errors++; $display("[TB] FAIL basic_issues: got %0d expected 4", issAddr.size()); end
    checks++; if (xData.size() != 4) begin errors++; $display("[TB] FAIL basic_xfers: got %0d expected 4", xData.size()); end
    for (int i = 0; i < 4 && i < xData.size() && i < issAddr.size(); i++) begin
      logic [AW-1:0] a;
      a = AW'(5) + AW'(i);
      checks++; if (issAddr[i] !== a) begin errors++; $display("[TB] FAIL basic_addr[%0d]: got %0d expected %0d", i, issAddr[i], a); end
      checks++; if (xData[i] !== rowOf(a)) begin errors++; $display("[TB] FAIL basic_data[%0d]: got %h expected %h", i, xData[i], rowOf(a)); end
      checks++; if (xCyc[i] != 2 + i) begin errors++; $display("[TB] FAIL basic_cycle[%0d]: got %0d expected %0d", i, xCyc[i], 2 + i); end
      checks++; if (xLast[i] !== (i == 3)) begin errors++; $display("[TB] FAIL basic_last[%0d]: got %b expected %b", i, xLast[i], (i == 3)); end
    end
    checks++; if (doneCyc != 6) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected 6", doneCyc); end
    checks++; if (busyAtDone !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_at_done: got %b expected 0", busyAtDone); end
  endtask

  task automatic test_wrap();
    runStream(AW'(1022), (AW+1)'(4), 0, 20, -1, -1);
    checks++; if (xData.size() != 4) begin errors++; $display("[TB] FAIL wrap_xfers: got %0d expected 4", xData.size()); end
    for (int i = 0; i < 4 && i < xData.size() && i < issAddr.size(); i++) begin
      logic [AW-1:0] a;
      a = AW'(1022) + AW'(i);
      checks++; if (issAddr[i] !== a) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %0d expected %0d", i, issAddr[i], a); end
      checks++; if (xData[i] !== rowOf(a)) begin errors++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", i, xData[i], rowOf(a)); end
      checks++; if (xLast[i] !== (i == 3)) begin errors++; $display("[TB] FAIL wrap_last[%0d]: got %b expected %b", i, xLast[i], (i == 3)); end
    end
    checks++; if (doneCyc != 6) begin errors++; $display("[TB] FAIL wrap_done_cycle: got %0d expected 6", doneCyc); end
  endtask

  task automatic test_backpressure();
    int bad;
    runStream(AW'(0), (AW+1)'(16), 1, 200, -1, -1);
    bad = 0;
    checks++; if (xData.size() != 16) begin errors++; $display("[TB] FAIL bp_xfers: got %0d expected 16", xData.size()); end
    checks++; if (issAddr.size() != 16) begin errors++; $display("[TB] FAIL bp_issues: got %0d expected 16", issAddr.size()); end
    for (int i = 0; i < xData.size() && i < 16; i++) begin
      if (xData[i] !== rowOf(AW'(i)) || xLast[i] !== (i == 15)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL bp_order: got %0d bad rows expected 0", bad); end
    checks++; if (stallViol != 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d unstable stalls expected 0", stallViol); end
    checks++; if (maxOut > 4) begin errors++; $display("[TB] FAIL bp_outstanding: got %0d expected <= 4", maxOut); end
    checks++;
    if (xCyc.size() != 16 || doneCyc != xCyc[15] + 1) begin
      errors++; $display("[TB] FAIL bp_done_cycle: got %0d expected one after last transfer", doneCyc);
    end
  endtask

  task automatic test_cmd_err();
    numRows = '0; baseAddr = AW'(3); start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (cmdErr !== 1'b1) begin errors++; $display("[TB] FAIL err_zero_pulse: got %b expected 1", cmdErr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL err_zero_busy: got %b expected 0", busy); end
    tick();
    checks++; if (cmdErr !== 1'b0) begin errors++; $display("[TB] FAIL err_zero_width: got %b expected 0", cmdErr); end
    checks++; if (memRdIssue !== 1'b0) begin errors++; $display("[TB] FAIL err_zero_issue: got %b expected 0", memRdIssue); end
    numRows = (AW+1)'(1025); start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (cmdErr !== 1'b1) begin errors++; $display("[TB] FAIL err_big_pulse: got %b expected 1", cmdErr); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL err_big_busy: got %b expected 0", busy); end
    runStream(AW'(200), (AW+1)'(6), 0, 40, 2, -1);
    checks++; if (errPulses != 1) begin errors++; $display("[TB] FAIL err_run_pulses: got %0d expected 1", errPulses); end
    checks++; if (xData.size() != 6) begin errors++; $display("[TB] FAIL err_run_xfers: got %0d expected 6", xData.size()); end
    checks++; if (xData.size() == 6 && xData[5] !== rowOf(AW'(205))) begin errors++; $display("[TB] FAIL err_run_data: got %h expected %h", xData[5], rowOf(AW'(205))); end
    checks++; if (doneCyc != 8) begin errors++; $display("[TB] FAIL err_run_done_cycle: got %0d expected 8", doneCyc); end
  endtask

  task automatic test_reset_mid();
    int doneSeen, validSeen;
    runStream(AW'(300), (AW+1)'(10), 0, 30, -1, 3);
    checks++; if (xData.size() != 3) begin errors++; $display("[TB] FAIL rmid_pre_xfers: got %0d expected 3", xData.size()); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_out_valid: got %b expected 0", outValid); end
    checks++; if (memRdIssue !== 1'b0) begin errors++; $display("[TB] FAIL rmid_rd_issue: got %b expected 0", memRdIssue); end
    checks++; if (memRdaddress !== '0) begin errors++; $display("[TB] FAIL rmid_rdaddress: got %0d expected 0", memRdaddress); end
    checks++; if (outData !== '0) begin errors++; $display("[TB] FAIL rmid_out_data: got %h expected 0", outData); end
    checks++; if (outLast !== 1'b0 || done !== 1'b0 || cmdErr !== 1'b0) begin errors++; $display("[TB] FAIL rmid_flags: got last=%b done=%b err=%b expected 0", outLast, done, cmdErr); end
    doneSeen = 0; validSeen = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (done) doneSeen++;
      if (outValid) validSeen++;
    end
    checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL rmid_no_done: got %0d expected 0", doneSeen); end
    checks++; if (validSeen != 0) begin errors++; $display("[TB] FAIL rmid_discard: got %0d expected 0", validSeen); end
    runStream(AW'(100), (AW+1)'(2), 0, 20, -1, -1);
    checks++; if (xData.size() != 2) begin errors++; $display("[TB] FAIL rmid_new_xfers: got %0d expected 2", xData.size()); end
    for (int i = 0; i < 2 && i < xData.size(); i++) begin
      checks++; if (xData[i] !== rowOf(AW'(100 + i))) begin errors++; $display("[TB] FAIL rmid_new_data[%0d]: got %h expected %h", i, xData[i], rowOf(AW'(100 + i))); end
      checks++; if (xLast[i] !== (i == 1)) begin errors++; $display("[TB] FAIL rmid_new_last[%0d]: got %b expected %b", i, xLast[i], (i == 1)); end
    end
    checks++; if (doneCyc != 4) begin errors++; $display("[TB] FAIL rmid_new_done: got %0d expected 4", doneCyc); end
  endtask

  task automatic test_full_range();
    int badData, badAddr;
    runStream(AW'(512), (AW+1)'(OFMAP_ROWS), 0, 1100, -1, -1);
    badData = 0; badAddr = 0;
    checks++; if (xData.size() != OFMAP_ROWS) begin errors++; $display("[TB] FAIL full_xfers: got %0d expected %0d", xData.size(), OFMAP_ROWS); end
    checks++; if (issAddr.size() != OFMAP_ROWS) begin errors++; $display("[TB] FAIL full_issues: got %0d expected %0d", issAddr.size(), OFMAP_ROWS); end
    for (int i = 0; i < xData.size() && i < OFMAP_ROWS; i++) begin
      if (xData[i] !== rowOf(AW'(512 + i)) || xCyc[i] != 2 + i || xLast[i] !== (i == OFMAP_ROWS - 1)) badData++;
    end
    for (int i = 0; i < issAddr.size() && i < OFMAP_ROWS; i++) begin
      if (issAddr[i] !== AW'(512 + i)) badAddr++;
    end
    checks++; if (badData != 0) begin errors++; $display("[TB] FAIL full_stream: got %0d bad rows expected 0", badData); end
    checks++; if (badAddr != 0) begin errors++; $display("[TB] FAIL full_addr: got %0d bad addresses expected 0", badAddr); end
    checks++; if (doneCyc != OFMAP_ROWS + 2) begin errors++; $display("[TB] FAIL full_done_cycle: got %0d expected %0d", doneCyc, OFMAP_ROWS + 2); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; baseAddr = '0; numRows = '0; outReady = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_cmd_err();
    test_reset_mid();
    test_full_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
